// File: rtl/seq_bit_serializer_if.sv
// Bus bundle for seq_bit_serializer: parallel word input with handshake plus serial output side.
// Handshake: a word transfers on a posedge where in_valid & in_ready are both 1; the producer
// holds in_data/in_valid stable while in_valid & !in_ready; in_ready never depends on in_valid.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_d;
  logic             ser_valid;
  logic             busy;
  logic [15:0]      words_sent;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_d, ser_valid, busy, words_sent
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_d, ser_valid, busy, words_sent
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: one bit per clock on ser_d, one-word holding buffer for gapless
// streaming, IDLE_BIT driven between words.
module seq_bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_bit_serializer_if.slave   bus,
  output logic                  state_dbg   // 1 while in SHIFT
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic             ser_d_q, ser_d_n;
  logic             ser_valid_q, ser_valid_n;
  logic [15:0]      ws, ws_n;
  logic             accept;
  logic             last_bit;

  // sh always holds the bits not yet driven; head() is the next one out.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign accept   = bus.in_valid & ~hold_full;
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  always_comb begin
    state_n     = state;
    sh_n        = sh;
    hold_n      = hold;
    hold_full_n = hold_full;
    bit_cnt_n   = bit_cnt;
    ser_d_n     = ser_d_q;
    ser_valid_n = ser_valid_q;
    ws_n        = ws;
    unique case (state)
      IDLE: begin
        ser_d_n     = IDLE_BIT;
        ser_valid_n = 1'b0;
        if (accept) begin
          state_n     = SHIFT;
          bit_cnt_n   = '0;
          ser_d_n     = head(bus.in_data);
          sh_n        = advance(bus.in_data);
          ser_valid_n = 1'b1;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          ws_n      = ws + 16'd1;
          bit_cnt_n = '0;
          if (hold_full) begin
            ser_d_n     = head(hold);
            sh_n        = advance(hold);
            hold_full_n = 1'b0;
          end else if (accept) begin
            // Hold is empty at the boundary, so a fresh word goes straight into sh.
            ser_d_n = head(bus.in_data);
            sh_n    = advance(bus.in_data);
          end else begin
            state_n     = IDLE;
            ser_valid_n = 1'b0;
            ser_d_n     = IDLE_BIT;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          ser_d_n   = head(sh);
          sh_n      = advance(sh);
          if (accept) begin
            hold_n      = bus.in_data;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sh          <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      ser_d_q     <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      ws          <= '0;
    end else begin
      state       <= state_n;
      sh          <= sh_n;
      hold        <= hold_n;
      hold_full   <= hold_full_n;
      bit_cnt     <= bit_cnt_n;
      ser_d_q     <= ser_d_n;
      ser_valid_q <= ser_valid_n;
      ws          <= ws_n;
    end
  end

  assign bus.in_ready   = ~hold_full;
  assign bus.busy       = (state == SHIFT) | hold_full;
  assign bus.ser_d      = ser_d_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.words_sent = ws;
  assign state_dbg      = (state == SHIFT);
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a word-queue model, plus literal bit-pattern checks.
module tb_seq_bit_serializer;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  bit           chk_en = 1'b0;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(W)) bus_m ();
  seq_bit_serializer_if #(.WIDTH(W)) bus_l ();
  assign bus_m.in_data  = in_data;
  assign bus_m.in_valid = in_valid;
  assign bus_l.in_data  = in_data;
  assign bus_l.in_valid = in_valid;

  logic dbg_m, dbg_l;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bus(bus_m), .state_dbg(dbg_m));
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .rst(rst), .bus(bus_l), .state_dbg(dbg_l));

  // ---------------- reference model ----------------
  // Words accepted but not finished; head is on the wire, bit index pos within it.
  logic [W-1:0] wq[$];
  int           pos = 0;
  logic [15:0]  m_sent = '0;
  bit           m_acc;

  always @(posedge clk) begin
    if (rst) begin
      wq.delete();
      pos    = 0;
      m_sent = '0;
    end else begin
      m_acc = in_valid && (wq.size() < 2);
      if (wq.size() > 0) begin
        if (pos == W - 1) begin
          void'(wq.pop_front());
          pos    = 0;
          m_sent = m_sent + 16'd1;
        end else begin
          pos++;
        end
      end
      if (m_acc) wq.push_back(in_data);
    end
  end

  function automatic logic exp_ser_d(input bit msb);
    logic [W-1:0] w;
    if (wq.size() == 0) return 1'b1;
    w = wq[0];
    return msb ? w[W-1-pos] : w[pos];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready",  bus_m.in_ready,   wq.size() < 2);
      check("m_busy",      bus_m.busy,       wq.size() > 0);
      check("m_state",     dbg_m,            wq.size() > 0);
      check("m_ser_valid", bus_m.ser_valid,  wq.size() > 0);
      check("m_ser_d",     bus_m.ser_d,      exp_ser_d(1'b1));
      check("m_words",     bus_m.words_sent, m_sent);
      check("l_in_ready",  bus_l.in_ready,   wq.size() < 2);
      check("l_busy",      bus_l.busy,       wq.size() > 0);
      check("l_state",     dbg_l,            wq.size() > 0);
      check("l_ser_valid", bus_l.ser_valid,  wq.size() > 0);
      check("l_ser_d",     bus_l.ser_d,      exp_ser_d(1'b0));
      check("l_words",     bus_l.words_sent, m_sent);
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a posedge; returns just after the edge where the word was accepted.
  task automatic send_word(input logic [W-1:0] w);
    bit rdy;
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = bus_m.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 50);
    if (!rdy) timeout_fail("send_word");
  endtask

  // Waits for ser_valid, then records n consecutive ser_d bits (first bit ends up most significant).
  task automatic capture(input bit msb, input int n, output logic [31:0] bits, output bit gap);
    int t;
    bits = '0;
    gap  = 1'b0;
    t    = 0;
    @(negedge clk);
    while (!(msb ? bus_m.ser_valid : bus_l.ser_valid) && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30) timeout_fail("capture_start");
    for (int i = 0; i < n; i++) begin
      if (!(msb ? bus_m.ser_valid : bus_l.ser_valid)) gap = 1'b1;
      bits = {bits[30:0], (msb ? bus_m.ser_d : bus_l.ser_d)};
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic check_idle(input string name, input logic [15:0] ws);
    check({name, "_valid"}, bus_m.ser_valid,  1'b0);
    check({name, "_d"},     bus_m.ser_d,      1'b1);
    check({name, "_ready"}, bus_m.in_ready,   1'b1);
    check({name, "_busy"},  bus_m.busy,       1'b0);
    check({name, "_words"}, bus_m.words_sent, ws);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] bits;
    bit          gap;
    bit          rdy;

    // T1 reset
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check_idle("t1", 16'd0);
    rst = 1'b0;

    // T2 single word, MSB first
    fork
      begin send_word(8'h28); in_valid = 1'b0; end
      capture(1'b1, 8, bits, gap);
    join
    check("t2_bits", bits[7:0], 8'b00101000);
    check("t2_gap", gap, 1'b0);
    @(posedge clk); #1;
    check_idle("t2_end", 16'd1);

    // T5 LSB first
    fork
      begin send_word(8'h14); in_valid = 1'b0; end
      capture(1'b0, 8, bits, gap);
    join
    check("t5_bits", bits[7:0], 8'b00101000);
    @(posedge clk); #1;
    check("t5_words", bus_l.words_sent, 16'd2);

    // T3 back-to-back through the holding buffer
    fork
      begin send_word(8'hA5); send_word(8'h3C); in_valid = 1'b0; end
      capture(1'b1, 16, bits, gap);
    join
    check("t3_bits", bits[15:0], 16'b10100101_00111100);
    check("t3_gap", gap, 1'b0);
    @(posedge clk); #1;
    check_idle("t3_end", 16'd4);

    // T4 second word offered only in the last-bit cycle of the first
    fork
      begin
        send_word(8'hC3);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        send_word(8'h5A);
        in_valid = 1'b0;
      end
      capture(1'b1, 16, bits, gap);
    join
    check("t4_bits", bits[15:0], 16'hC35A);
    check("t4_gap", gap, 1'b0);
    @(posedge clk); #1;
    check_idle("t4_end", 16'd6);

    // T6 reset mid-word with hold full
    send_word(8'h96);
    send_word(8'h69);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_pre_valid", bus_m.ser_valid, 1'b1);
    check("t6_pre_ready", bus_m.in_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("t6_rst", 16'd0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_idle("t6_after", 16'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rdy = bus_m.in_ready;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      if (!in_valid || rdy) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = W'($urandom);
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("final_idle", bus_m.ser_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
